// File: rtl/jtframe_z80_pkg.sv
// Purpose : shared types and elaboration helpers for the Z80 ROM bank mapper.
// Latency : n/a (package).
// Backpressure : n/a (package).
package jtframe_z80_pkg;

  localparam int CPU_AW = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  // Number of 2^win_aw byte windows in the CPU address space
  function automatic int slot_count(input int win_aw);
    return 1 << (CPU_AW - win_aw);
  endfunction

  // Fixed plus banked windows must fit in the CPU map; 1..4 banked windows
  function automatic bit range_ok(input int win_aw, input int fixed_n, input int windows_n);
    return ((fixed_n + windows_n) <= slot_count(win_aw)) &&
           (windows_n >= 1) && (windows_n <= 4);
  endfunction

endpackage

// File: rtl/jtframe_romwait.sv
// Purpose : stalls the CPU clock enable from a new ROM request until rom_ok, with a timeout watchdog.
// Latency : request cycle plus at least one WAIT cycle (2 clk minimum stall); cpu_cen returns the cycle after release.
// Backpressure : cpu_cen is held low while waiting; a stuck rom_ok is released after TIMEOUT WAIT cycles.
// Ports: i_clk/i_rst (sync, active-high), i_cen raw enable, i_rom_cs/i_rom_addr/i_rom_ok slot handshake,
//        o_cpu_cen gated enable, o_timeout_err sticky forced-release flag.
module jtframe_romwait
  import jtframe_z80_pkg::*;
#(
  parameter int AW      = 20,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cen,
  input  logic          i_rom_cs,
  input  logic [AW-1:0] i_rom_addr,
  input  logic          i_rom_ok,
  output logic          o_cpu_cen,
  output logic          o_timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  wait_state_t   r_state;
  wait_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_cs_d;
  logic [AW-1:0] r_addr_d;
  logic          r_terr;
  logic          w_terr_set;
  logic          w_new_req;

  // A fresh request is a rom_cs rising edge or a new address under a held rom_cs
  assign w_new_req = i_rom_cs && (!r_cs_d || (i_rom_addr != r_addr_d));

  // Saturating increment: the counter never wraps back to zero
  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cs_d   <= 1'b0;
      r_addr_d <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cs_d   <= i_rom_cs;
      r_addr_d <= i_rom_addr;
      if (w_terr_set) r_terr <= 1'b1;
    end
  end

  // The request cycle itself is the blanking cycle: rom_ok there belongs to the
  // previous address, so it is only honoured once the FSM sits in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_terr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_req) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (!i_rom_cs) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_new_req) begin
          w_cnt_nxt   = '0;
        end else if (i_rom_ok) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = w_cnt_inc;
          w_terr_set  = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_cpu_cen = 1'b0;
    if (r_state == ST_IDLE && !w_new_req) o_cpu_cen = i_cen;
  end

  assign o_timeout_err = r_terr;

endmodule

// File: rtl/jtframe_z80_bankmap.sv
// Purpose : decodes fixed/banked ROM windows for a Z80, holds the bank registers and gates the CPU enable on ROM fetches.
// Latency : rom_cs/rom_addr/bank_rd/bank_dout combinational; bank writes land on the IORQ write edge; fetch stall >= 2 clk.
// Backpressure : cpu_cen is held low until rom_ok (or the timeout watchdog) releases the fetch.
// Ports: i_clk/i_rst, i_cen -> o_cpu_cen, Z80 bus (i_a, strobes, i_cpu_dout), ROM slot (o_rom_addr, o_rom_cs, i_rom_ok),
//        bank read-back (o_bank_rd, o_bank_dout), o_banks (register 0 in LSBs), o_timeout_err.
module jtframe_z80_bankmap
  import jtframe_z80_pkg::*;
#(
  parameter int         WIN_AW    = 14,
  parameter int         FIXED     = 2,
  parameter int         WINDOWS   = 1,
  parameter int         BANK_W    = 4,
  parameter int         ROM_AW    = 20,
  parameter logic [4:0] BANK_PORT = 5'h02,
  parameter int         TIMEOUT   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cen,
  output logic                        o_cpu_cen,
  input  logic [15:0]                 i_a,
  input  logic                        i_mreq_n,
  input  logic                        i_iorq_n,
  input  logic                        i_rd_n,
  input  logic                        i_wr_n,
  input  logic                        i_rfsh_n,
  input  logic [7:0]                  i_cpu_dout,
  output logic [ROM_AW-1:0]           o_rom_addr,
  output logic                        o_rom_cs,
  input  logic                        i_rom_ok,
  output logic                        o_bank_rd,
  output logic [7:0]                  o_bank_dout,
  output logic [WINDOWS*BANK_W-1:0]   o_banks,
  output logic                        o_timeout_err
);

  localparam int SW = CPU_AW - WIN_AW;

  if (!range_ok(WIN_AW, FIXED, WINDOWS)) begin : g_range_chk
    $error("jtframe_z80_bankmap: FIXED+WINDOWS exceeds the slot count or WINDOWS outside 1..4");
  end

  logic [BANK_W-1:0] r_banks [WINDOWS];
  logic [ROM_AW-1:0] r_addr_hold;
  logic [SW-1:0]     w_slot;
  logic [31:0]       w_slot_ext;
  logic              w_is_fixed;
  logic              w_is_bank;
  logic [BANK_W-1:0] w_bank_val;
  logic [ROM_AW-1:0] w_page;
  logic [ROM_AW-1:0] w_addr_new;
  logic [WINDOWS-1:0] w_port_hit;
  logic              w_unused;

  assign w_unused   = ^i_cpu_dout;
  assign w_slot     = i_a[15:WIN_AW];
  assign w_slot_ext = 32'(w_slot);
  assign w_is_fixed = w_slot_ext < 32'(FIXED);
  assign w_is_bank  = !w_is_fixed && (w_slot_ext < 32'(FIXED + WINDOWS));

  always_comb begin
    w_bank_val = '0;
    for (int k = 0; k < WINDOWS; k++) begin
      if (w_slot_ext == 32'(FIXED + k)) w_bank_val = r_banks[k];
    end
  end

  // Banked pages sit above the fixed ones in ROM; the sum wraps at ROM_AW bits
  assign w_page     = w_is_fixed ? ROM_AW'(w_slot) : ROM_AW'(FIXED) + ROM_AW'(w_bank_val);
  assign w_addr_new = (w_page << WIN_AW) | ROM_AW'(i_a[WIN_AW-1:0]);

  assign o_rom_cs   = !i_mreq_n && i_rfsh_n && (w_is_fixed || w_is_bank);
  // Holding the address while idle keeps the SDRAM slot from seeing spurious changes
  assign o_rom_addr = o_rom_cs ? w_addr_new : r_addr_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr_hold <= '0;
    end else if (o_rom_cs) begin
      r_addr_hold <= w_addr_new;
    end
  end

  always_comb begin
    for (int k = 0; k < WINDOWS; k++) begin
      w_port_hit[k] = (i_a[4:0] == 5'(BANK_PORT + k));
    end
  end

  // Level-sensitive write: a multi-cycle IORQ simply rewrites the same value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < WINDOWS; k++) r_banks[k] <= '0;
    end else if (!i_iorq_n && !i_wr_n) begin
      for (int k = 0; k < WINDOWS; k++) begin
        if (w_port_hit[k]) r_banks[k] <= i_cpu_dout[BANK_W-1:0];
      end
    end
  end

  assign o_bank_rd = !i_iorq_n && !i_rd_n && (|w_port_hit);

  always_comb begin
    o_bank_dout = '0;
    for (int k = 0; k < WINDOWS; k++) begin
      if (w_port_hit[k]) o_bank_dout = 8'(r_banks[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < WINDOWS; k++) o_banks[k*BANK_W +: BANK_W] = r_banks[k];
  end

  jtframe_romwait #(
    .AW      (ROM_AW),
    .TIMEOUT (TIMEOUT)
  ) u_romwait (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cen         (i_cen),
    .i_rom_cs      (o_rom_cs),
    .i_rom_addr    (o_rom_addr),
    .i_rom_ok      (i_rom_ok),
    .o_cpu_cen     (o_cpu_cen),
    .o_timeout_err (o_timeout_err)
  );

endmodule
